// File: rtl/fp_issue_queue.sv
// FP reservation station ahead of the FALU: collapsing queue that holds ops until both
// sources are ready, snoops writeback, and issues the oldest ready op through registered outputs.
module fp_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int ROB_LEN = 32,
    parameter int ROB_W   = $clog2(ROB_LEN),
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [4:0]        disp_funct5,
    input  logic [ROB_W-1:0]  disp_rob_idx,
    input  logic [6:0]        disp_rd,
    input  logic [6:0]        disp_rs1,
    input  logic [6:0]        disp_rs2,
    input  logic              disp_rs1_rdy,
    input  logic              disp_rs2_rdy,
    input  logic [DATA_W-1:0] disp_rs1_data,
    input  logic [DATA_W-1:0] disp_rs2_data,
    input  logic              wb_valid,
    input  logic [6:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              falu_i_valid,
    output logic [4:0]        funct5,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic [ROB_W-1:0]  falu_i_rob_idx,
    output logic [6:0]        falu_i_rd
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0]        funct5;
        logic [ROB_W-1:0]  rob;
        logic [6:0]        rd;
        logic [6:0]        tag1;
        logic              rdy1;
        logic [DATA_W-1:0] dat1;
        logic [6:0]        tag2;
        logic              rdy2;
        logic [DATA_W-1:0] dat2;
    } entry_t;

    // Shared by resident-entry wakeup and the dispatch bypass: same match rule for both.
    function automatic entry_t wake(input entry_t e, input logic v,
                                    input logic [6:0] tag, input logic [DATA_W-1:0] d);
        entry_t r;
        r = e;
        if (v && !e.rdy1 && e.tag1 == tag) begin
            r.rdy1 = 1'b1;
            r.dat1 = d;
        end
        if (v && !e.rdy2 && e.tag2 == tag) begin
            r.rdy2 = 1'b1;
            r.dat2 = d;
        end
        return r;
    endfunction

    entry_t             ent_q    [DEPTH];
    entry_t             ent_d    [DEPTH];
    entry_t             shift_in [DEPTH];
    entry_t             new_e;
    logic [CNT_W-1:0]   count_q, count_d, wr_idx;
    logic [IDX_W-1:0]   sel;
    logic               found, issue_fire, disp_fire;

    logic               vld_q;
    logic [4:0]         f5_q;
    logic [DATA_W-1:0]  op1_q, op2_q;
    logic [ROB_W-1:0]   rob_q;
    logic [6:0]         rd_q;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && CNT_W'(i) < count_q && ent_q[i].rdy1 && ent_q[i].rdy2) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end
        issue_fire = found && !flush;
        disp_ready = count_q < CNT_W'(DEPTH);
        disp_fire  = disp_valid && disp_ready && !flush;
        wr_idx     = count_q - CNT_W'(issue_fire);

        new_e.funct5 = disp_funct5;
        new_e.rob    = disp_rob_idx;
        new_e.rd     = disp_rd;
        new_e.tag1   = disp_rs1;
        new_e.rdy1   = disp_rs1_rdy;
        new_e.dat1   = disp_rs1_data;
        new_e.tag2   = disp_rs2;
        new_e.rdy2   = disp_rs2_rdy;
        new_e.dat2   = disp_rs2_data;

        for (int i = 0; i < DEPTH - 1; i++) shift_in[i] = ent_q[i + 1];
        shift_in[DEPTH-1] = ent_q[DEPTH-1];

        // Collapse first, then wake, so captured data lands in the entry's new slot.
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = wake((issue_fire && i >= int'(sel)) ? shift_in[i] : ent_q[i],
                            wb_valid, wb_rd, wb_data);
            if (disp_fire && CNT_W'(i) == wr_idx)
                ent_d[i] = wake(new_e, wb_valid, wb_rd, wb_data);
        end

        if (flush) count_d = '0;
        else       count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            vld_q   <= 1'b0;
            f5_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            rob_q   <= '0;
            rd_q    <= '0;
        end else begin
            count_q <= count_d;
            vld_q   <= issue_fire;
            if (issue_fire) begin
                f5_q  <= ent_q[sel].funct5;
                op1_q <= ent_q[sel].dat1;
                op2_q <= ent_q[sel].dat2;
                rob_q <= ent_q[sel].rob;
                rd_q  <= ent_q[sel].rd;
            end
        end
    end

    // Slot payload is qualified by count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end

    assign falu_i_valid   = vld_q;
    assign funct5         = f5_q;
    assign operand1       = op1_q;
    assign operand2       = op2_q;
    assign falu_i_rob_idx = rob_q;
    assign falu_i_rd      = rd_q;

endmodule

// File: tb/tb_fp_issue_queue.sv
// Directed bench for fp_issue_queue: a scoreboard queue of expected issues is filled as
// stimulus is driven and drained by a monitor whenever falu_i_valid is seen.
module tb_fp_issue_queue;

    localparam logic [4:0] FADDS = 5'b00000;
    localparam logic [4:0] FSUBS = 5'b00001;

    logic        clk = 0;
    logic        rst, flush, disp_valid, disp_ready;
    logic [4:0]  disp_funct5;
    logic [4:0]  disp_rob_idx;
    logic [6:0]  disp_rd, disp_rs1, disp_rs2;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    logic [31:0] disp_rs1_data, disp_rs2_data;
    logic        wb_valid;
    logic [6:0]  wb_rd;
    logic [31:0] wb_data;
    logic        falu_i_valid;
    logic [4:0]  funct5;
    logic [31:0] operand1, operand2;
    logic [4:0]  falu_i_rob_idx;
    logic [6:0]  falu_i_rd;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  f5;
        logic [4:0]  rob;
        logic [6:0]  rd;
        logic [31:0] o1;
        logic [31:0] o2;
    } exp_t;
    exp_t exp_q[$];

    fp_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_funct5(disp_funct5), .disp_rob_idx(disp_rob_idx), .disp_rd(disp_rd),
        .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .falu_i_valid(falu_i_valid), .funct5(funct5),
        .operand1(operand1), .operand2(operand2),
        .falu_i_rob_idx(falu_i_rob_idx), .falu_i_rd(falu_i_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [4:0] f5, input logic [4:0] rob, input logic [6:0] rd,
                        input logic [6:0] t1, input logic r1, input logic [31:0] d1,
                        input logic [6:0] t2, input logic r2, input logic [31:0] d2);
        disp_valid = 1; disp_funct5 = f5; disp_rob_idx = rob; disp_rd = rd;
        disp_rs1 = t1; disp_rs1_rdy = r1; disp_rs1_data = d1;
        disp_rs2 = t2; disp_rs2_rdy = r2; disp_rs2_data = d2;
    endtask

    task automatic push(input logic [4:0] f5, input logic [4:0] rob, input logic [6:0] rd,
                        input logic [31:0] o1, input logic [31:0] o2);
        exp_t e;
        e.f5 = f5; e.rob = rob; e.rd = rd; e.o1 = o1; e.o2 = o2;
        exp_q.push_back(e);
    endtask

    task automatic wb(input logic [6:0] tag, input logic [31:0] d);
        wb_valid = 1; wb_rd = tag; wb_data = d;
    endtask

    // Scoreboard monitor, sampling well after each rising edge.
    always @(posedge clk) begin
        #2;
        if (rst && falu_i_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue_rob", 32'(falu_i_rob_idx), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("iss_funct5", 32'(funct5), 32'(e.f5));
                chk("iss_rob", 32'(falu_i_rob_idx), 32'(e.rob));
                chk("iss_rd", 32'(falu_i_rd), 32'(e.rd));
                chk("iss_op1", operand1, e.o1);
                chk("iss_op2", operand2, e.o2);
            end
        end
    end

    initial begin
        rst = 0; flush = 0; disp_valid = 0; disp_funct5 = 0; disp_rob_idx = 0; disp_rd = 0;
        disp_rs1 = 0; disp_rs2 = 0; disp_rs1_rdy = 0; disp_rs2_rdy = 0;
        disp_rs1_data = 0; disp_rs2_data = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        tick(); tick();
        chk("rst_valid", 32'(falu_i_valid), 0);
        chk("rst_op1", operand1, 0);
        chk("rst_rd", 32'(falu_i_rd), 0);
        chk("rst_ready", 32'(disp_ready), 1);
        rst = 1;
        tick();

        // Ready dispatch: 1 cycle dispatch-to-issue
        disp(FADDS, 2, 9, 1, 1, 32'h3F800000, 2, 1, 32'h40000000);
        push(FADDS, 2, 9, 32'h3F800000, 32'h40000000);
        tick(); disp_valid = 0;
        chk("rdy_lat0", 32'(falu_i_valid), 0);
        tick();
        chk("rdy_issue", 32'(falu_i_valid), 1);
        tick();
        chk("rdy_pulse", 32'(falu_i_valid), 0);
        chk("rdy_hold_op1", operand1, 32'h3F800000);

        // Wakeup via writeback bus
        disp(FSUBS, 3, 10, 1, 1, 32'h41000000, 17, 0, 32'hDEADBEEF);
        tick(); disp_valid = 0;
        tick(); tick(); tick();
        chk("wk_wait", 32'(falu_i_valid), 0);
        wb(17, 32'h40400000);
        push(FSUBS, 3, 10, 32'h41000000, 32'h40400000);
        tick(); wb_valid = 0;
        chk("wk_no_same_cycle", 32'(falu_i_valid), 0);
        tick();
        chk("wk_issue", 32'(falu_i_valid), 1);
        tick();

        // Dispatch bypass of a same-cycle writeback
        disp(FADDS, 4, 11, 5, 0, 32'h12345678, 6, 1, 32'h3F800000);
        wb(5, 32'h40A00000);
        push(FADDS, 4, 11, 32'h40A00000, 32'h3F800000);
        tick(); disp_valid = 0; wb_valid = 0;
        tick();
        chk("byp_issue", 32'(falu_i_valid), 1);
        tick();

        // Fill, out-of-order wakeup, collapse
        for (int i = 0; i < 4; i++) begin
            disp(FADDS, 5'(8 + i), 7'(20 + i), 1, 1, 32'h1000 + 32'(i), 7'(30 + i), 0, 0);
            tick();
            chk("fill_ready", 32'(disp_ready), (i < 3) ? 1 : 0);
        end
        disp_valid = 0;
        wb(32, 32'hAAAA0002);
        push(FADDS, 10, 22, 32'h1002, 32'hAAAA0002);
        tick();
        chk("full_with_issue_ready", 32'(disp_ready), 0);
        // dispatch attempt while full must be dropped (it would otherwise issue)
        disp(FSUBS, 15, 99, 1, 1, 32'hEEEE, 2, 1, 32'hEEEE);
        wb(30, 32'hAAAA0000);
        push(FADDS, 8, 20, 32'h1000, 32'hAAAA0000);
        tick(); disp_valid = 0; wb_valid = 0;
        chk("after_first_issue_ready", 32'(disp_ready), 1);
        tick();
        chk("entry0_issue", 32'(falu_i_valid), 1);
        wb(31, 32'hAAAA0001);
        push(FADDS, 9, 21, 32'h1001, 32'hAAAA0001);
        tick();
        // entry3 wakes while the slot below it issues; new ready op dispatched same cycle
        wb(33, 32'hAAAA0003);
        disp(FSUBS, 12, 24, 3, 1, 32'h2222, 4, 1, 32'h3333);
        push(FADDS, 11, 23, 32'h1003, 32'hAAAA0003);
        push(FSUBS, 12, 24, 32'h2222, 32'h3333);
        tick(); wb_valid = 0; disp_valid = 0;
        tick(); tick(); tick();
        chk("drain_idle", 32'(falu_i_valid), 0);

        // Flush with a ready entry and a same-cycle dispatch
        for (int i = 0; i < 3; i++) begin
            disp(FADDS, 5'(16 + i), 7'(40 + i), 1, 1, 32'h5, 7'(40 + i), 0, 0);
            tick();
        end
        disp_valid = 0;
        wb(40, 32'h77);
        tick(); wb_valid = 0;
        flush = 1;
        disp(FADDS, 20, 60, 1, 1, 32'h9, 2, 1, 32'h9);
        tick(); flush = 0; disp_valid = 0;
        chk("flush_valid", 32'(falu_i_valid), 0);
        chk("flush_ready", 32'(disp_ready), 1);
        for (int i = 0; i < 4; i++) begin
            disp(FADDS, 5'(21 + i), 7'(50 + i), 1, 1, 32'h6, 7'(50 + i), 0, 0);
            tick();
            chk("post_flush_ready", 32'(disp_ready), (i < 3) ? 1 : 0);
        end
        disp_valid = 0;
        wb(41, 32'h1); tick();
        wb(42, 32'h1); tick(); wb_valid = 0;
        tick();
        chk("flush_no_issue", 32'(falu_i_valid), 0);

        // Reset mid-operation with 3 entries
        wb(50, 32'hC0000000);
        push(FADDS, 21, 50, 32'h6, 32'hC0000000);
        tick(); wb_valid = 0;
        tick();
        chk("pre_rst_issue", 32'(falu_i_valid), 1);
        #2 rst = 0;
        #1;
        chk("arst_valid", 32'(falu_i_valid), 0);
        chk("arst_op1", operand1, 0);
        chk("arst_op2", operand2, 0);
        chk("arst_rob", 32'(falu_i_rob_idx), 0);
        chk("arst_ready", 32'(disp_ready), 1);
        tick(); rst = 1;
        wb(51, 32'h2); tick();
        wb(52, 32'h2); tick();
        wb(53, 32'h2); tick(); wb_valid = 0;
        tick();
        chk("rst_no_issue", 32'(falu_i_valid), 0);
        disp(FSUBS, 7, 3, 1, 1, 32'h40E00000, 2, 1, 32'h3F000000);
        push(FSUBS, 7, 3, 32'h40E00000, 32'h3F000000);
        tick(); disp_valid = 0;
        tick();
        chk("post_rst_issue", 32'(falu_i_valid), 1);
        tick(); tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
